// File: rtl/ysyx_24080006_mem_arbiter_pkg.sv
// Shared memory-port types: arbiter FSM/owner encodings, LSU access size encoding and byte-strobe lookup.
package ysyx_24080006_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RSP  = 2'b10
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

    localparam lsu_size_e IFU_SIZE = SIZE_W;

    // Byte strobes for an access of the given size at the given byte offset within the word.
    function automatic logic [3:0] wstrb_lut(input lsu_size_e size, input logic [1:0] off);
        case (size)
            SIZE_B:  return 4'b0001 << off;
            SIZE_H:  return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_24080006_mem_arbiter_if.sv
// One request/response memory channel; master issues requests and accepts responses, slave serves them.
interface ysyx_24080006_mem_arbiter_if;
    import ysyx_24080006_mem_arbiter_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    lsu_size_e   req_size;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_write, req_wdata, req_wstrb, req_size, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata, req_wstrb, req_size, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/ysyx_24080006_mem_arbiter.sv
// IFU/LSU arbiter for the single memory port; request/response paths are combinational, one IDLE cycle per grant.
// Owner holds the port from grant until its response handshake; non-owner sees ready/valid low and waits.
module ysyx_24080006_mem_arbiter
    import ysyx_24080006_mem_arbiter_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    ysyx_24080006_mem_arbiter_if.slave     ifu,
    ysyx_24080006_mem_arbiter_if.slave     lsu,
    ysyx_24080006_mem_arbiter_if.master    mem
);

    arb_state_e state_q;
    arb_owner_e owner_q;
    arb_owner_e last_grant_q;
    arb_owner_e grant_d;

    logic req_hs;
    logic rsp_hs;

    assign req_hs = mem.req_valid & mem.req_ready;
    assign rsp_hs = mem.rsp_valid & mem.rsp_ready;

    always_comb begin
        grant_d = OWN_IFU;
        if (lsu.req_valid && !ifu.req_valid) begin
            grant_d = OWN_LSU;
        end else if (lsu.req_valid && ifu.req_valid) begin
            if (FAIR) begin
                grant_d = (last_grant_q == OWN_IFU) ? OWN_LSU : OWN_IFU;
            end else begin
                grant_d = OWN_LSU;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_LSU;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ifu.req_valid || lsu.req_valid) begin
                        owner_q      <= grant_d;
                        last_grant_q <= grant_d;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    if (req_hs) begin
                        state_q <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_hs) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Everything not steered to/from the current owner is held at zero.
    always_comb begin
        mem.req_valid = 1'b0;
        mem.req_addr  = 32'd0;
        mem.req_write = 1'b0;
        mem.req_wdata = 32'd0;
        mem.req_wstrb = 4'b0000;
        mem.req_size  = SIZE_B;
        mem.rsp_ready = 1'b0;
        ifu.req_ready = 1'b0;
        ifu.rsp_valid = 1'b0;
        ifu.rsp_rdata = 32'd0;
        ifu.rsp_err   = 1'b0;
        lsu.req_ready = 1'b0;
        lsu.rsp_valid = 1'b0;
        lsu.rsp_rdata = 32'd0;
        lsu.rsp_err   = 1'b0;

        if (state_q == REQ) begin
            if (owner_q == OWN_IFU) begin
                mem.req_valid = ifu.req_valid;
                mem.req_addr  = ifu.req_addr;
                mem.req_size  = IFU_SIZE;
                ifu.req_ready = mem.req_ready;
            end else begin
                mem.req_valid = lsu.req_valid;
                mem.req_addr  = lsu.req_addr;
                mem.req_write = lsu.req_write;
                mem.req_wdata = lsu.req_wdata;
                mem.req_wstrb = lsu.req_wstrb;
                mem.req_size  = lsu.req_size;
                lsu.req_ready = mem.req_ready;
            end
        end

        if (state_q == RSP) begin
            if (owner_q == OWN_IFU) begin
                ifu.rsp_valid = mem.rsp_valid;
                ifu.rsp_rdata = mem.rsp_rdata;
                ifu.rsp_err   = mem.rsp_err;
                mem.rsp_ready = ifu.rsp_ready;
            end else begin
                lsu.rsp_valid = mem.rsp_valid;
                lsu.rsp_rdata = mem.rsp_rdata;
                lsu.rsp_err   = mem.rsp_err;
                mem.rsp_ready = lsu.rsp_ready;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_mem_arbiter.sv
// Directed bench: fetch, stalled store, round-robin vs fixed-priority ties, queued LSU, error response, reset mid-RSP.
module tb_ysyx_24080006_mem_arbiter;
    import ysyx_24080006_mem_arbiter_pkg::*;

    logic clk_i;
    logic rst_i;

    ysyx_24080006_mem_arbiter_if ifu_a ();
    ysyx_24080006_mem_arbiter_if lsu_a ();
    ysyx_24080006_mem_arbiter_if mem_a ();
    ysyx_24080006_mem_arbiter_if ifu_b ();
    ysyx_24080006_mem_arbiter_if lsu_b ();
    ysyx_24080006_mem_arbiter_if mem_b ();

    ysyx_24080006_mem_arbiter dut_a (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ifu   (ifu_a),
        .lsu   (lsu_a),
        .mem   (mem_a)
    );

    ysyx_24080006_mem_arbiter #(.FAIR(1'b0)) dut_b (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ifu   (ifu_b),
        .lsu   (lsu_b),
        .mem   (mem_b)
    );

    int n_chk;
    int n_fail;
    int pulses;
    int ka;
    int kb;
    logic [31:0] exp_a [3];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    task automatic mid();
        #3;
    endtask

    // IFU fields it never should forward are set to junk so the forced constants are visible.
    task automatic idle_all();
        ifu_a.req_valid = 1'b0; ifu_a.req_addr = 32'd0; ifu_a.req_write = 1'b1;
        ifu_a.req_wdata = 32'hFFFF_FFFF; ifu_a.req_wstrb = 4'hF; ifu_a.req_size = SIZE_B;
        ifu_a.rsp_ready = 1'b1;
        lsu_a.req_valid = 1'b0; lsu_a.req_addr = 32'd0; lsu_a.req_write = 1'b0;
        lsu_a.req_wdata = 32'd0; lsu_a.req_wstrb = 4'h0; lsu_a.req_size = SIZE_W;
        lsu_a.rsp_ready = 1'b1;
        mem_a.req_ready = 1'b0; mem_a.rsp_valid = 1'b0; mem_a.rsp_rdata = 32'd0; mem_a.rsp_err = 1'b0;
        ifu_b.req_valid = 1'b0; ifu_b.req_addr = 32'd0; ifu_b.req_write = 1'b0;
        ifu_b.req_wdata = 32'd0; ifu_b.req_wstrb = 4'h0; ifu_b.req_size = SIZE_W;
        ifu_b.rsp_ready = 1'b1;
        lsu_b.req_valid = 1'b0; lsu_b.req_addr = 32'd0; lsu_b.req_write = 1'b0;
        lsu_b.req_wdata = 32'd0; lsu_b.req_wstrb = 4'h0; lsu_b.req_size = SIZE_W;
        lsu_b.rsp_ready = 1'b1;
        mem_b.req_ready = 1'b0; mem_b.rsp_valid = 1'b0; mem_b.rsp_rdata = 32'd0; mem_b.rsp_err = 1'b0;
    endtask

    task automatic sample_ties();
        if (mem_a.req_valid) begin
            if (ka < 3) chk("t3_rr_grant", mem_a.req_addr, exp_a[ka]);
            ka++;
        end
        if (mem_b.req_valid) begin
            chk("t3_fixed_grant", mem_b.req_addr, 32'h2000_0000);
            kb++;
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        exp_a[0] = 32'h1000_0000;
        exp_a[1] = 32'h2000_0000;
        exp_a[2] = 32'h1000_0000;
        rst_i = 1'b1;
        idle_all();

        @(negedge clk_i);
        chk("rst_ifu_req_rdy", 32'(ifu_a.req_ready), 32'd0);
        chk("rst_lsu_req_rdy", 32'(lsu_a.req_ready), 32'd0);
        chk("rst_mem_req_vld", 32'(mem_a.req_valid), 32'd0);
        chk("rst_mem_rsp_rdy", 32'(mem_a.rsp_ready), 32'd0);
        chk("rst_ifu_rsp_vld", 32'(ifu_a.rsp_valid), 32'd0);
        chk("rst_lsu_rsp_vld", 32'(lsu_a.rsp_valid), 32'd0);
        cyc();
        rst_i = 1'b0;

        // IFU-only fetch, zero-wait downstream
        cyc(); ifu_a.req_valid = 1'b1; ifu_a.req_addr = 32'h3000_0000; mid();
        chk("t1_idle_ifu_rdy", 32'(ifu_a.req_ready), 32'd0);
        chk("t1_idle_mem_vld", 32'(mem_a.req_valid), 32'd0);
        cyc(); mem_a.req_ready = 1'b1; mid();
        chk("t1_mem_vld", 32'(mem_a.req_valid), 32'd1);
        chk("t1_mem_addr", mem_a.req_addr, 32'h3000_0000);
        chk("t1_mem_write", 32'(mem_a.req_write), 32'd0);
        chk("t1_mem_size", 32'(mem_a.req_size), 32'd2);
        chk("t1_mem_wstrb", 32'(mem_a.req_wstrb), 32'd0);
        chk("t1_mem_wdata", mem_a.req_wdata, 32'd0);
        chk("t1_ifu_rdy", 32'(ifu_a.req_ready), 32'd1);
        chk("t1_lsu_rdy", 32'(lsu_a.req_ready), 32'd0);
        cyc(); ifu_a.req_valid = 1'b0; mem_a.req_ready = 1'b0;
        mem_a.rsp_valid = 1'b1; mem_a.rsp_rdata = 32'h0000_0413; mid();
        chk("t1_ifu_rsp_vld", 32'(ifu_a.rsp_valid), 32'd1);
        chk("t1_ifu_rsp_rdata", ifu_a.rsp_rdata, 32'h0000_0413);
        chk("t1_ifu_rsp_err", 32'(ifu_a.rsp_err), 32'd0);
        chk("t1_mem_rsp_rdy", 32'(mem_a.rsp_ready), 32'd1);
        chk("t1_lsu_rsp_vld", 32'(lsu_a.rsp_valid), 32'd0);
        chk("t1_lsu_rsp_rdata", lsu_a.rsp_rdata, 32'd0);
        cyc(); mem_a.rsp_valid = 1'b0; mid();
        chk("t1_back_idle_rsp", 32'(ifu_a.rsp_valid), 32'd0);
        chk("t1_back_idle_mem", 32'(mem_a.req_valid), 32'd0);

        // LSU store with downstream ready delayed 3 cycles
        pulses = 0;
        cyc(); lsu_a.req_valid = 1'b1; lsu_a.req_addr = 32'h8000_0010; lsu_a.req_write = 1'b1;
        lsu_a.req_wdata = 32'hDEAD_BEEF; lsu_a.req_wstrb = 4'b0011; lsu_a.req_size = SIZE_H; mid();
        if (lsu_a.req_ready) pulses++;
        for (int i = 0; i < 3; i++) begin
            cyc(); mid();
            chk("t2_stall_vld", 32'(mem_a.req_valid), 32'd1);
            chk("t2_stall_addr", mem_a.req_addr, 32'h8000_0010);
            chk("t2_stall_wdata", mem_a.req_wdata, 32'hDEAD_BEEF);
            chk("t2_stall_wstrb", 32'(mem_a.req_wstrb), 32'h3);
            chk("t2_stall_write", 32'(mem_a.req_write), 32'd1);
            chk("t2_stall_size", 32'(mem_a.req_size), 32'd1);
            if (lsu_a.req_ready) pulses++;
        end
        cyc(); mem_a.req_ready = 1'b1; mid();
        chk("t2_lsu_rdy", 32'(lsu_a.req_ready), 32'd1);
        if (lsu_a.req_ready) pulses++;
        cyc(); lsu_a.req_valid = 1'b0; lsu_a.req_write = 1'b0; mem_a.req_ready = 1'b0;
        mem_a.rsp_valid = 1'b1; mem_a.rsp_rdata = 32'd0; mid();
        chk("t2_lsu_rsp_vld", 32'(lsu_a.rsp_valid), 32'd1);
        chk("t2_ifu_rsp_vld", 32'(ifu_a.rsp_valid), 32'd0);
        if (lsu_a.req_ready) pulses++;
        cyc(); mem_a.rsp_valid = 1'b0; mid();
        if (lsu_a.req_ready) pulses++;
        chk("t2_rdy_pulses", 32'(pulses), 32'd1);

        // Simultaneous requests, three rounds, on both the fair and fixed-priority instances
        ka = 0;
        kb = 0;
        cyc();
        ifu_a.req_valid = 1'b1; ifu_a.req_addr = 32'h1000_0000;
        lsu_a.req_valid = 1'b1; lsu_a.req_addr = 32'h2000_0000; lsu_a.req_size = SIZE_W;
        mem_a.req_ready = 1'b1; mem_a.rsp_valid = 1'b1;
        ifu_b.req_valid = 1'b1; ifu_b.req_addr = 32'h1000_0000;
        lsu_b.req_valid = 1'b1; lsu_b.req_addr = 32'h2000_0000;
        mem_b.req_ready = 1'b1; mem_b.rsp_valid = 1'b1;
        mid(); sample_ties();
        for (int i = 0; i < 8; i++) begin
            cyc(); mid(); sample_ties();
        end
        cyc(); idle_all(); mid();
        chk("t3_rr_rounds", 32'(ka), 32'd3);
        chk("t3_fixed_rounds", 32'(kb), 32'd3);

        // LSU queued behind IFU response stall, then LSU load with error
        cyc(); ifu_a.req_valid = 1'b1; ifu_a.req_addr = 32'h3000_0004; mid();
        cyc(); mem_a.req_ready = 1'b1; mid();
        chk("t4_ifu_rdy", 32'(ifu_a.req_ready), 32'd1);
        cyc(); ifu_a.req_valid = 1'b0; mem_a.req_ready = 1'b0; mem_a.rsp_valid = 1'b1;
        mem_a.rsp_rdata = 32'h0000_0013; ifu_a.rsp_ready = 1'b0;
        lsu_a.req_valid = 1'b1; lsu_a.req_addr = 32'h8000_0020; mid();
        chk("t4_stall0_mem_rdy", 32'(mem_a.rsp_ready), 32'd0);
        chk("t4_stall0_ifu_vld", 32'(ifu_a.rsp_valid), 32'd1);
        chk("t4_stall0_lsu_rdy", 32'(lsu_a.req_ready), 32'd0);
        cyc(); mid();
        chk("t4_stall1_mem_rdy", 32'(mem_a.rsp_ready), 32'd0);
        chk("t4_stall1_lsu_rdy", 32'(lsu_a.req_ready), 32'd0);
        cyc(); ifu_a.rsp_ready = 1'b1; mid();
        chk("t4_release_mem_rdy", 32'(mem_a.rsp_ready), 32'd1);
        chk("t4_release_lsu_rdy", 32'(lsu_a.req_ready), 32'd0);
        cyc(); mem_a.rsp_valid = 1'b0; mid();
        chk("t4_bubble_lsu_rdy", 32'(lsu_a.req_ready), 32'd0);
        chk("t4_bubble_mem_vld", 32'(mem_a.req_valid), 32'd0);
        cyc(); mem_a.req_ready = 1'b1; mid();
        chk("t4_lsu_mem_vld", 32'(mem_a.req_valid), 32'd1);
        chk("t4_lsu_mem_addr", mem_a.req_addr, 32'h8000_0020);
        chk("t4_lsu_rdy", 32'(lsu_a.req_ready), 32'd1);
        cyc(); lsu_a.req_valid = 1'b0; mem_a.req_ready = 1'b0; mem_a.rsp_valid = 1'b1;
        mem_a.rsp_rdata = 32'hCAFE_F00D; mem_a.rsp_err = 1'b1; mid();
        chk("t5_lsu_rsp_vld", 32'(lsu_a.rsp_valid), 32'd1);
        chk("t5_lsu_rsp_err", 32'(lsu_a.rsp_err), 32'd1);
        chk("t5_lsu_rsp_rdata", lsu_a.rsp_rdata, 32'hCAFE_F00D);
        chk("t5_ifu_rsp_vld", 32'(ifu_a.rsp_valid), 32'd0);
        chk("t5_ifu_rsp_err", 32'(ifu_a.rsp_err), 32'd0);
        cyc(); mem_a.rsp_valid = 1'b0; mem_a.rsp_err = 1'b0; mid();
        chk("t5_idle_lsu_vld", 32'(lsu_a.rsp_valid), 32'd0);
        chk("t5_idle_mem_vld", 32'(mem_a.req_valid), 32'd0);

        // Reset while IFU owns RSP; afterwards a tie must go to IFU again
        cyc(); ifu_a.req_valid = 1'b1; ifu_a.req_addr = 32'h3000_0008; mid();
        cyc(); mem_a.req_ready = 1'b1; mid();
        cyc(); ifu_a.req_valid = 1'b0; mem_a.req_ready = 1'b0; mem_a.rsp_valid = 1'b1;
        mem_a.rsp_rdata = 32'h1111_2222; ifu_a.rsp_ready = 1'b0; mid();
        chk("t6_pre_rst_vld", 32'(ifu_a.rsp_valid), 32'd1);
        cyc(); rst_i = 1'b1; #1;
        chk("t6_rst_ifu_rsp_vld", 32'(ifu_a.rsp_valid), 32'd0);
        chk("t6_rst_ifu_rsp_rdata", ifu_a.rsp_rdata, 32'd0);
        chk("t6_rst_mem_rsp_rdy", 32'(mem_a.rsp_ready), 32'd0);
        chk("t6_rst_mem_req_vld", 32'(mem_a.req_valid), 32'd0);
        chk("t6_rst_lsu_rsp_vld", 32'(lsu_a.rsp_valid), 32'd0);
        cyc(); rst_i = 1'b0; mem_a.rsp_valid = 1'b0; ifu_a.rsp_ready = 1'b1;
        ifu_a.req_valid = 1'b1; ifu_a.req_addr = 32'h1000_0000;
        lsu_a.req_valid = 1'b1; lsu_a.req_addr = 32'h2000_0000; mid();
        chk("t6_idle_mem_vld", 32'(mem_a.req_valid), 32'd0);
        cyc(); mem_a.req_ready = 1'b1; mid();
        chk("t6_tie_addr", mem_a.req_addr, 32'h1000_0000);
        chk("t6_tie_ifu_rdy", 32'(ifu_a.req_ready), 32'd1);
        chk("t6_tie_lsu_rdy", 32'(lsu_a.req_ready), 32'd0);
        cyc(); idle_all(); mid();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_24080006_mem_arbiter.md
# ysyx_24080006_mem_arbiter

Two-master, one-slave arbiter sharing the core's single memory port between instruction fetch (IFU, read-only, fed by icache refill) and the load/store unit (LSU). It grants one requester at a time, forwards its request to the downstream memory/bus bridge, and steers the response back to the owner. It holds ownership from grant until the response handshake completes. It sits between IFU/LSU and the bus bridge in the core top level.

## Interface
- FAIR, default 1: 1 = round-robin on simultaneous requests; 0 = fixed LSU priority.
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- ifu_req_valid / ifu_req_ready  in / out  1  IFU request handshake
- ifu_req_addr  in  32  fetch address
- ifu_rsp_valid / ifu_rsp_ready  out / in  1  IFU response handshake
- ifu_rsp_rdata  out  32  fetched word
- ifu_rsp_err  out  1  access error
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_req_addr  in  32  data address
- lsu_req_write  in  1  1 = store
- lsu_req_wdata  in  32  store data
- lsu_req_wstrb  in  4  byte strobes (per WSTRB_LUT)
- lsu_req_size  in  2  lsu_size encoding
- lsu_rsp_valid / lsu_rsp_ready  out / in  1  LSU response handshake
- lsu_rsp_rdata  out  32  load data
- lsu_rsp_err  out  1  access error
- mem_req_valid / mem_req_ready  out / in  1  downstream request handshake
- mem_req_addr, mem_req_write, mem_req_wdata, mem_req_wstrb, mem_req_size  out  32/1/32/4/2  muxed request fields
- mem_rsp_valid / mem_rsp_ready  in / out  1  downstream response handshake
- mem_rsp_rdata  in  32  read data
- mem_rsp_err  in  1  error

## Operation
- States: IDLE, REQ, RSP. Registers: state, owner (OWN_IFU/OWN_LSU), last_grant.
- IDLE: if any req_valid, latch owner per arbitration and go to REQ. No ready is asserted in IDLE.
- Arbitration: a single requester wins. If both request, FAIR=1 grants the requester that is not last_grant; FAIR=0 grants the LSU. last_grant is updated at grant.
- REQ: mem_req_valid = owner's req_valid. mem_req_* fields are combinationally muxed from the owner. Owner's req_ready = mem_req_ready. On the handshake, go to RSP. The non-owner's req_ready is 0.
- IFU path drives mem_req_write=0, wstrb=4'b0000, size=2'b10, wdata=0.
- RSP: owner's rsp_valid = mem_rsp_valid, with rdata/err passed through. mem_rsp_ready = owner's rsp_ready. On the handshake, go to IDLE. The non-owner's rsp_valid is 0.
- Requesters hold req fields stable while valid and not yet accepted. A requester must not drop valid before ready.
- The downstream returns its response no earlier than the cycle after request acceptance. mem_rsp_valid is ignored outside RSP.
- Reset values: state=IDLE, owner=OWN_IFU, last_grant=OWN_LSU (first tie goes to IFU). All valid/ready outputs are 0. Data outputs are 0 while not steered.
- Reset mid-transaction: return to IDLE immediately and drop all handshake outputs. The downstream shares the reset and abandons the transfer.

## Timing
- req_valid seen in IDLE at cycle N → mem_req_valid at N+1.
- Zero-wait downstream (ready at N+1, response at N+2): owner sees rsp_valid at N+2. If rsp_ready=1, the arbiter is back in IDLE at N+3.
- Back-to-back requests from the same or the other master have one IDLE bubble between the response handshake and the next grant.
- A request arriving while another owner is in REQ/RSP waits. It is arbitrated in the next IDLE cycle.
- Request and response paths are combinational through the arbiter. Only state, owner and last_grant are registered.

## Structure
- Add to the shared package: arb_state_e {IDLE, REQ, RSP}; arb_owner_e {OWN_IFU, OWN_LSU}; IFU fixed size constant 2'b10.
- Reuse lsu_size encoding and WSTRB_LUT from the package.
- No sub-module. The grant logic is a few lines inside this module.

## Test plan
- IFU-only fetch, addr 0x3000_0000, rdata 0x0000_0413, zero-wait: mem_req_valid at N+1 with write=0 and size=2'b10; ifu_rsp_valid at N+2 with rdata 0x0000_0413; lsu_* ready/valid stay 0.
- LSU store: addr 0x8000_0010, wdata 0xDEAD_BEEF, wstrb 4'b0011, downstream ready delayed 3 cycles. mem_req_* fields are stable across the stall; lsu_req_ready pulses exactly once.
- Simultaneous IFU+LSU requests, FAIR=1, three rounds: grant order is IFU, LSU, IFU. With FAIR=0, LSU wins every tie.
- LSU request arrives while IFU owns RSP: it is not accepted until the IFU response handshake completes plus one IDLE cycle. ifu_rsp_ready held low for 2 cycles stalls mem_rsp_ready for those 2 cycles.
- mem_rsp_err=1 on an LSU load: lsu_rsp_err=1 and lsu_rsp_valid=1. The arbiter returns to IDLE normally.
- Assert reset during RSP: all valid/ready outputs are 0 within the same cycle. After release, state=IDLE and the first tie goes to IFU.
